mem_port_arbiter: RTL and testbench

- Shares one external memory port between the hart's instruction-fetch side and data side.
- Sits between the HART instruction/data memory interfaces and a single unified memory.
- Latches one request at a time, sequences it on the shared port, and returns read data plus a one-cycle ready pulse to the owning requester.
- A watchdog aborts transactions the memory never completes.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data requesters, one transaction at a time, with a watchdog abort.
// Define ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous requests instead of favouring data.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic [XLEN-1:0] o_if_rdata,
  output logic            o_if_ready,
  input  logic            i_dm_ren,
  input  logic            i_dm_wen,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wdata,
  input  logic [2:0]      i_dm_f3,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_err,
  output logic            o_mem_req,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [2:0]      o_mem_f3,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [2:0]       F3_WORD = 3'b010;

  // IDLE: arbitrate | BUSY: drive shared port | RESP: owner ready pulse
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q;
  logic              owner_dm_q;
  logic              mem_req_q;
  logic              wen_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        f3_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [XLEN-1:0]   if_rdata_q;
  logic [XLEN-1:0]   dm_rdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_dm_q;
`endif

  logic              dm_req;
  logic              grant_dm_d;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    dm_req = i_dm_ren | i_dm_wen;
`ifdef ARB_ROUND_ROBIN_EN
    grant_dm_d = (dm_req && i_if_req) ? ~last_dm_q : dm_req;
`else
    grant_dm_d = dm_req;
`endif
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      owner_dm_q <= 1'b0;
      mem_req_q  <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q  <= 1'b1;
`endif
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_req || i_if_req) begin
            owner_dm_q <= grant_dm_d;
            addr_q     <= grant_dm_d ? i_dm_addr : i_if_addr;
            wdata_q    <= grant_dm_d ? i_dm_wdata : '0;
            f3_q       <= grant_dm_d ? i_dm_f3 : F3_WORD;
            wen_q      <= grant_dm_d & i_dm_wen;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (i_mem_ready) begin
            if (owner_dm_q) dm_rdata_q <= i_mem_rdata;
            else            if_rdata_q <= i_mem_rdata;
            dm_ready_q <= owner_dm_q;
            if_ready_q <= ~owner_dm_q;
            mem_req_q  <= 1'b0;
            wen_q      <= 1'b0;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_d;
            // Abort on the cycle the count reaches TIMEOUT; the memory's late ready is then ignored.
            if (cnt_d == TO_CNT) begin
              if (owner_dm_q) dm_rdata_q <= '0;
              else            if_rdata_q <= '0;
              dm_ready_q <= owner_dm_q;
              if_ready_q <= ~owner_dm_q;
              err_q      <= 1'b1;
              mem_req_q  <= 1'b0;
              wen_q      <= 1'b0;
              state_q    <= RESP;
            end
          end
        end
        RESP: begin
          err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_dm_q <= owner_dm_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_if_rdata  = if_rdata_q;
  assign o_if_ready  = if_ready_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_dm_ready  = dm_ready_q;
  assign o_err       = err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_f3    = f3_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/fetch contention, watchdog abort, async reset, field stability.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic [XLEN-1:0] o_if_rdata;
  logic            o_if_ready;
  logic            i_dm_ren;
  logic            i_dm_wen;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wdata;
  logic [2:0]      i_dm_f3;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_dm_ready;
  logic            o_err;
  logic            o_mem_req;
  logic            o_mem_wen;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [2:0]      o_mem_f3;
  logic            i_mem_ready;
  logic [XLEN-1:0] i_mem_rdata;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  last_dm  = 1'b1;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(4), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
    .i_dm_ren(i_dm_ren), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .i_dm_f3(i_dm_f3), .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_f3(o_mem_f3), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected winner of the current IDLE arbitration.
  function automatic bit exp_win_dm(input bit ifr, input bit dmr);
    if (RR && ifr && dmr) return !last_dm;
    return dmr;
  endfunction

  // Called one cycle into BUSY; completes the transaction and returns in IDLE.
  task automatic run_txn(input string tag, input bit exp_dm, input logic [31:0] exp_addr,
                         input logic exp_wen, input logic [31:0] exp_wdata, input logic [2:0] exp_f3,
                         input logic [31:0] rdata);
    check({tag, "_req"}, o_mem_req, 1);
    check({tag, "_addr"}, o_mem_addr, exp_addr);
    check({tag, "_wen"}, o_mem_wen, exp_wen);
    check({tag, "_f3"}, o_mem_f3, exp_f3);
    if (exp_wen) check({tag, "_wdata"}, o_mem_wdata, exp_wdata);
    i_mem_ready = 1'b1;
    i_mem_rdata = rdata;
    tick();
    i_mem_ready = 1'b0;
    check({tag, "_dm_rdy"}, o_dm_ready, exp_dm);
    check({tag, "_if_rdy"}, o_if_ready, !exp_dm);
    if (exp_dm && !exp_wen) check({tag, "_dm_rdata"}, o_dm_rdata, rdata);
    if (!exp_dm)            check({tag, "_if_rdata"}, o_if_rdata, rdata);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_req_low"}, o_mem_req, 0);
    if (exp_dm) begin i_dm_ren = 1'b0; i_dm_wen = 1'b0; end
    else        i_if_req = 1'b0;
    last_dm = exp_dm;
    tick();
    check({tag, "_rdy_clr"}, {o_if_ready, o_dm_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit w;
    i_rst = 1'b1;
    i_if_req = 0; i_if_addr = '0;
    i_dm_ren = 0; i_dm_wen = 0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_f3 = '0;
    i_mem_ready = 0; i_mem_rdata = '0;
    tick(); tick();
    check("rst_outs", {o_mem_req, o_mem_wen, o_if_ready, o_dm_ready, o_err}, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_rdata", o_dm_rdata | o_if_rdata, 0);
    i_rst = 1'b0;
    tick();
    check("idle_req", o_mem_req, 0);

    // Single fetch at minimum latency
    i_if_req = 1; i_if_addr = 32'h100;
    tick();
    run_txn("fetch", 1'b0, 32'h100, 1'b0, 32'h0, 3'b010, 32'hDEADBEEF);

    // Simultaneous store and fetch
    i_if_req = 1; i_if_addr = 32'h200;
    i_dm_wen = 1; i_dm_addr = 32'h8000_0000; i_dm_wdata = 32'h1234_5678; i_dm_f3 = 3'b010;
    tick();
    w = exp_win_dm(1, 1);
    if (w) run_txn("both_st", 1'b1, 32'h8000_0000, 1'b1, 32'h1234_5678, 3'b010, 32'h0);
    else   run_txn("both_if", 1'b0, 32'h200, 1'b0, 32'h0, 3'b010, 32'h1111_0000);
    tick();
    if (w) run_txn("both_if2", 1'b0, 32'h200, 1'b0, 32'h0, 3'b010, 32'h1111_0001);
    else   run_txn("both_st2", 1'b1, 32'h8000_0000, 1'b1, 32'h1234_5678, 3'b010, 32'h0);

    // Repeated contention; odd rounds are preceded by a lone load to move the round-robin pointer
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) begin
        i_dm_ren = 1; i_dm_addr = 32'h600 + i; i_dm_f3 = 3'b100;
        tick();
        run_txn("lone_ld", 1'b1, 32'h600 + i, 1'b0, 32'h0, 3'b100, 32'h5500_0000 + i);
      end
      i_if_req = 1; i_if_addr = 32'h300 + 4 * i;
      i_dm_ren = 1; i_dm_addr = 32'h700 + 4 * i; i_dm_f3 = 3'b001;
      tick();
      w = exp_win_dm(1, 1);
      if (w) run_txn("rr_d", 1'b1, 32'h700 + 4 * i, 1'b0, 32'h0, 3'b001, 32'hA000_0000 + i);
      else   run_txn("rr_i", 1'b0, 32'h300 + 4 * i, 1'b0, 32'h0, 3'b010, 32'hB000_0000 + i);
      tick();
      if (w) run_txn("rr_i2", 1'b0, 32'h300 + 4 * i, 1'b0, 32'h0, 3'b010, 32'hB000_0010 + i);
      else   run_txn("rr_d2", 1'b1, 32'h700 + 4 * i, 1'b0, 32'h0, 3'b001, 32'hA000_0010 + i);
    end

    // Stalled memory: abort after 4 BUSY cycles
    i_dm_ren = 1; i_dm_addr = 32'h40; i_dm_f3 = 3'b100;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("stall_busy", {o_mem_req, o_dm_ready, o_err}, 3'b100);
      tick();
    end
    check("stall_req", o_mem_req, 1);
    tick();
    check("to_ready", o_dm_ready, 1);
    check("to_err", o_err, 1);
    check("to_rdata", o_dm_rdata, 0);
    check("to_if_hold", o_if_rdata, RR ? 32'hB000_0003 : 32'hB000_0013);
    check("to_req_low", o_mem_req, 0);
    i_dm_ren = 0;
    last_dm = 1'b1;
    tick();
    check("to_idle", {o_err, o_dm_ready}, 0);

    // Memory ready on the 4th BUSY cycle beats the watchdog
    i_dm_ren = 1; i_dm_addr = 32'h44;
    tick();
    tick(); tick(); tick();
    check("late_req", o_mem_req, 1);
    i_mem_ready = 1; i_mem_rdata = 32'hCAFE_F00D;
    tick();
    i_mem_ready = 0;
    check("late_ready", o_dm_ready, 1);
    check("late_err", o_err, 0);
    check("late_rdata", o_dm_rdata, 32'hCAFE_F00D);
    i_dm_ren = 0;
    tick();

    // Asynchronous reset during BUSY
    i_if_req = 1; i_if_addr = 32'h500;
    tick();
    check("mid_busy", o_mem_req, 1);
    #2 i_rst = 1'b1;
    #1 check("rst_async_req", o_mem_req, 0);
    tick();
    check("rst_no_ready", {o_if_ready, o_dm_ready, o_err}, 0);
    i_rst = 1'b0;
    last_dm = 1'b1;
    tick();
    run_txn("reissue", 1'b0, 32'h500, 1'b0, 32'h0, 3'b010, 32'h0BAD_F00D);

    // Field changes during BUSY are ignored
    i_dm_ren = 1; i_dm_addr = 32'h10; i_dm_f3 = 3'b010;
    tick();
    i_dm_addr = 32'h20;
    tick();
    check("stable_addr", o_mem_addr, 32'h10);
    run_txn("stable", 1'b1, 32'h10, 1'b0, 32'h0, 3'b010, 32'h7777_0010);

    // Stray memory ready in IDLE
    i_mem_ready = 1; i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    i_mem_ready = 0;
    check("stray_req", o_mem_req, 0);
    tick();
    check("stray_ready", {o_if_ready, o_dm_ready, o_err}, 0);
    check("stray_rdata", o_dm_rdata, 32'h7777_0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
